signed_booth_multiplier: RTL

- Sequential radix-2 Booth multiplier for two's-complement operands. It is the multiply-direction counterpart of the team's signed restoring divider and shares its operand width and its Start/Done style.
- Sits beside the divider in the arithmetic datapath.
- Produces a full-width signed product after a fixed WIDTH iterations, one iteration per clock.

---
 rtl/mul_defs.sv | 10 +
 rtl/signed_booth_multiplier_booth_step.sv | 33 +++
 rtl/signed_booth_multiplier.sv | 98 +++++++++
 3 files changed

// File: rtl/mul_defs.sv
// Shared multiply/divide definitions: controller state encodings and default operand width.
package mul_defs;
  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/signed_booth_multiplier_booth_step.sv
// One radix-2 Booth iteration: add/subtract/no-op on the accumulator, then an
// arithmetic right shift of {acc, q, q_1} by one bit.
module booth_step
  import mul_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Shifting drops the old q_1; the accumulator sign bit is replicated.
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/signed_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: WIDTH iterations per product, Start/Busy/Done handshake.
module signed_booth_multiplier
  import mul_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int COUNT_W = $clog2(WIDTH + 1);

  state_t               state_reg;
  logic [WIDTH:0]       acc_reg;
  logic [WIDTH:0]       m_reg;
  logic [WIDTH-1:0]     q_reg;
  logic                 q_1_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [WIDTH:0]       acc_next;
  logic [WIDTH-1:0]     q_next;
  logic                 q_1_next;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            acc_reg   <= '0;
            m_reg     <= {Multiplicand[WIDTH-1], Multiplicand};
            q_reg     <= Multiplier;
            q_1_reg   <= 1'b0;
            count_reg <= COUNT_W'(WIDTH);
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          q_1_reg   <= q_1_next;
          count_reg <= count_reg - COUNT_W'(1);
          // Last step: publish the product from the step output in the same edge.
          if (count_reg == COUNT_W'(1)) begin
            product_reg <= {acc_next[WIDTH-1:0], q_next};
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign Product = product_reg;

endmodule
